// File: rtl/exe_wb_pipe.sv
// EXE->WB register chain of STAGES slots with stall, flush, retired-write counter; EXE_WB_FWD_EN adds fwd lookup.
// Latency: STAGES-1 clk from acceptance to outputs with an empty, unstalled chain; 1 entry/clk throughput.
// Backpressure: out_ready=0 holds the output slot, upstream bubbles collapse, in_ready drops when all slots are full.
module exe_wb_pipe #(
  parameter int DSIZE  = 32,
  parameter int ASIZE  = 5,
  parameter int STAGES = 2,
  parameter int CNTW   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] aluout_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] aluout_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out,
`ifdef EXE_WB_FWD_EN
  input  logic [ASIZE-1:0] fwd_raddr,
  output logic             fwd_hit,
  output logic [DSIZE-1:0] fwd_data,
`endif
  output logic [CNTW-1:0]  wb_count
);

  typedef struct packed {
    logic [DSIZE-1:0] d;
    logic [ASIZE-1:0] a;
    logic             w;
  } entry_t;

  logic [STAGES-1:0] v;
  entry_t            slot [STAGES];
  logic [STAGES-1:0] mv;
  logic [STAGES-1:0] free;
  logic              accept;
  logic              out_hs;
  entry_t            in_ent;

  // mv[i]: the content of slot i leaves it at the next edge (if it holds one).
  always_comb begin
    mv = '0;
    mv[STAGES-1] = out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      mv[i] = !v[i+1] || mv[i+1];
    end
    free = ~v | mv;
  end

  assign in_ent   = '{d: aluout_in, a: waddr_in, w: wen_in};
  assign in_ready = !flush && free[0];
  assign accept   = in_valid && in_ready;

  assign out_valid  = v[STAGES-1];
  assign aluout_out = slot[STAGES-1].d;
  assign waddr_out  = slot[STAGES-1].a;
  assign wen_out    = v[STAGES-1] && slot[STAGES-1].w;
  assign out_hs     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        v[i]    <= 1'b0;
        slot[i] <= '0;
      end
      wb_count <= '0;
    end else begin
      // A handshake in a flush cycle still retires and counts.
      if (out_hs && slot[STAGES-1].w) begin
        wb_count <= wb_count + CNTW'(1);
      end
      if (flush) begin
        for (int i = 0; i < STAGES; i++) begin
          v[i]      <= 1'b0;
          slot[i].w <= 1'b0;
        end
      end else begin
        for (int i = STAGES - 1; i >= 1; i--) begin
          if (v[i-1] && free[i]) begin
            slot[i] <= slot[i-1];
            v[i]    <= 1'b1;
          end else if (mv[i]) begin
            v[i] <= 1'b0;
          end
        end
        if (accept) begin
          slot[0] <= in_ent;
          v[0]    <= 1'b1;
        end else if (mv[0]) begin
          v[0] <= 1'b0;
        end
      end
    end
  end

`ifdef EXE_WB_FWD_EN
  // Scan oldest to youngest so the youngest (lowest index) match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (v[i] && slot[i].w && (slot[i].a == fwd_raddr) && (fwd_raddr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = slot[i].d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exe_wb_pipe.sv
// Directed bench for exe_wb_pipe (STAGES=2, CNTW=4): reset, latency, stall, flush, counter wrap, forwarding.
// Inputs driven 1 time unit after posedge; outputs sampled in the same window once logic has settled.
// Stimulus is fixed-length; no open-ended waits on the DUT.
module tb_exe_wb_pipe;

  localparam int DSIZE  = 32;
  localparam int ASIZE  = 5;
  localparam int STAGES = 2;
  localparam int CNTW   = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] aluout_in;
  logic [ASIZE-1:0] waddr_in;
  logic             wen_in;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] aluout_out;
  logic [ASIZE-1:0] waddr_out;
  logic             wen_out;
  logic [CNTW-1:0]  wb_count;
`ifdef EXE_WB_FWD_EN
  logic [ASIZE-1:0] fwd_raddr;
  logic             fwd_hit;
  logic [DSIZE-1:0] fwd_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  exe_wb_pipe #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .STAGES(STAGES), .CNTW(CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .aluout_in  (aluout_in),
    .waddr_in   (waddr_in),
    .wen_in     (wen_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .aluout_out (aluout_out),
    .waddr_out  (waddr_out),
    .wen_out    (wen_out),
`ifdef EXE_WB_FWD_EN
    .fwd_raddr  (fwd_raddr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
`endif
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] d, input logic [4:0] a, input logic w);
    in_valid  = vld;
    aluout_in = d;
    waddr_in  = a;
    wen_in    = w;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hDEAD, 5'd9, 1'b1);
`ifdef EXE_WB_FWD_EN
    fwd_raddr = '0;
`endif

    // Reset held 2 clk with in_valid=1
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_aluout",    aluout_out,     32'd0);
    chk("rst_waddr",     32'(waddr_out), 32'd0);
    chk("rst_wen",       32'(wen_out),   32'd0);
    chk("rst_wb_count",  32'(wb_count),  32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // A then B back to back, out_ready high
    drive(1'b1, 32'h11, 5'd3, 1'b1);
    tick();
    drive(1'b1, 32'h22, 5'd4, 1'b0);
    tick();
    chk("lat_a_valid", 32'(out_valid), 32'd1);
    chk("lat_a_data",  aluout_out,     32'h11);
    chk("lat_a_addr",  32'(waddr_out), 32'd3);
    chk("lat_a_wen",   32'(wen_out),   32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("lat_b_data",  aluout_out,     32'h22);
    chk("lat_b_wen",   32'(wen_out),   32'd0);
    chk("lat_cnt1",    32'(wb_count),  32'd1);
    tick();
    chk("lat_empty",   32'(out_valid), 32'd0);
    chk("lat_cnt1b",   32'(wb_count),  32'd1);

    // Stall while streaming C, D, E
    out_ready = 1'b0;
    drive(1'b1, 32'h31, 5'd1, 1'b1);
    #1;
    chk("stall_rdy0", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 32'h32, 5'd2, 1'b1);
    chk("stall_rdy1", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 32'h33, 5'd6, 1'b1);
    chk("stall_rdy2", 32'(in_ready), 32'd0);
    tick();
    chk("stall_hold1", aluout_out, 32'h31);
    chk("stall_vld",   32'(out_valid), 32'd1);
    tick();
    chk("stall_hold2", aluout_out, 32'h31);
    chk("stall_addr",  32'(waddr_out), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("stall_rdy3", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("drain_d",    aluout_out,    32'h32);
    chk("drain_cnt2", 32'(wb_count), 32'd2);
    tick();
    chk("drain_e",    aluout_out,    32'h33);
    chk("drain_cnt3", 32'(wb_count), 32'd3);
    tick();
    chk("drain_cnt4", 32'(wb_count),  32'd4);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Flush with two valid slots, input pending, output stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h41, 5'd7, 1'b1);
    tick();
    drive(1'b1, 32'h42, 5'd8, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h43, 5'd10, 1'b1);
    #1;
    chk("flush_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("flush_vld1", 32'(out_valid), 32'd0);
    chk("flush_rdy2", 32'(in_ready),  32'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("flush_vld2", 32'(out_valid), 32'd0);
    chk("flush_wen",  32'(wen_out),   32'd0);
    chk("flush_cnt",  32'(wb_count),  32'd4);
    tick();
    chk("flush_vld3", 32'(out_valid), 32'd0);

    // Counter wrap: 11 more writes reach 15, one more wraps to 0
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, 32'h100 + 32'(k), 5'd2, 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();
    chk("wrap_cnt15", 32'(wb_count), 32'd15);
    drive(1'b1, 32'h200, 5'd2, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("wrap_last_data", aluout_out, 32'h200);
    tick();
    chk("wrap_cnt0", 32'(wb_count), 32'd0);

`ifdef EXE_WB_FWD_EN
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd5, 1'b1);
    tick();
    drive(1'b1, 32'hB, 5'd5, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    fwd_raddr = 5'd5;
    #1;
    chk("fwd_hit5",  32'(fwd_hit), 32'd1);
    chk("fwd_data5", fwd_data,     32'hB);
    fwd_raddr = 5'd0;
    #1;
    chk("fwd_hit0",  32'(fwd_hit), 32'd0);
    chk("fwd_data0", fwd_data,     32'h0);
    fwd_raddr = 5'd3;
    #1;
    chk("fwd_miss",  32'(fwd_hit), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
